// File: rtl/word_transmitter_pkg.sv
// word_transmitter_pkg: shared widths and FSM state encoding for word_transmitter
// Holds WORD_W, ADDR_W and the state enum. GAP exists only when WORD_TX_GAP_EN is defined.
package word_transmitter_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 12;
  localparam int BIT_W = $clog2(WORD_W);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SETUP = 3'd3,
    HIGH  = 3'd4,
`ifdef WORD_TX_GAP_EN
    GAP   = 3'd5,
`endif
    DONE  = 3'd6
  } state_t;
endpackage

// File: rtl/word_transmitter_if.sv
// word_transmitter_if: request, memory and serial-line signals of word_transmitter
// master: the requester and memory side. It drives start, base_addr, word_count and mem_data.
// slave: the transmitter side. It drives addr, dataPin, dataOnPin, busy and done.
interface word_transmitter_if;
  import word_transmitter_pkg::*;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic [WORD_W-1:0] mem_data;
  logic [ADDR_W-1:0] addr;
  logic              dataPin;
  logic              dataOnPin;
  logic              busy;
  logic              done;
  modport master (
    output start, base_addr, word_count, mem_data,
    input  addr, dataPin, dataOnPin, busy, done
  );
  modport slave (
    input  start, base_addr, word_count, mem_data,
    output addr, dataPin, dataOnPin, busy, done
  );
endinterface

// File: rtl/word_tx_strobe_gen.sv
// word_tx_strobe_gen: CLK_DIV-cycle phase counter for the SETUP/HIGH strobe phases
// Ports: clk, reset (async active-low), en (a strobe phase is active), tick (last cycle of the current phase).
module word_tx_strobe_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt_q, cnt_d;
  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));
  // The counter restarts at every phase boundary, so each SETUP or HIGH phase starts from zero.
  always_comb begin
    cnt_d = (en && !tick) ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/word_transmitter.sv
// word_transmitter: sends a burst of memory words as LSB-first serial bits with a bit strobe
// Ports: clk and reset (async active-low). bus is the slave modport of word_transmitter_if.
// Inputs on bus: start, base_addr, word_count, mem_data. Outputs on bus: addr, dataPin, dataOnPin, busy, done.
// Macro WORD_TX_GAP_EN: when defined, GAP_CYCLES idle cycles are inserted between consecutive words.
module word_transmitter
  import word_transmitter_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 8
) (
  input logic clk,
  input logic reset,
  word_transmitter_if.slave bus
);
  if (CLK_DIV < 1 || CLK_DIV > 255 || GAP_CYCLES < 1) begin : g_bad_param
    $error("word_transmitter: CLK_DIV must be 1..255 and GAP_CYCLES must be >= 1");
  end
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rem_q, rem_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              data_pin_q, data_pin_d, data_on_pin_q, data_on_pin_d;
  logic              strobe_en, tick;
`ifdef WORD_TX_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif
  assign strobe_en = (state_q == SETUP) || (state_q == HIGH);
  word_tx_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk   (clk),
    .reset (reset),
    .en    (strobe_en),
    .tick  (tick)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef WORD_TX_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      // busy_q lags state by one cycle. Gating on it also rejects start in the cycle right after DONE.
      IDLE: if (bus.start && !busy_q) begin
        addr_d  = bus.base_addr;
        rem_d   = bus.word_count;
        state_d = (bus.word_count != '0) ? FETCH : DONE;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = bus.mem_data;
        bit_d   = '0;
        state_d = SETUP;
      end
      SETUP: state_d = tick ? HIGH : SETUP;
      HIGH: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BIT_W'(1);
        state_d = SETUP;
        if (bit_q == BIT_W'(WORD_W - 1)) begin
          rem_d  = rem_q - ADDR_W'(1);
          addr_d = addr_q + ADDR_W'(1);
`ifdef WORD_TX_GAP_EN
          gap_d   = '0;
          state_d = (rem_q == ADDR_W'(1)) ? DONE : GAP;
`else
          state_d = (rem_q == ADDR_W'(1)) ? DONE : FETCH;
`endif
        end
      end
`ifdef WORD_TX_GAP_EN
      GAP: begin
        gap_d   = gap_q + GAP_W'(1);
        state_d = (gap_q == GAP_LAST) ? FETCH : GAP;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the current state. They trail state_q by one cycle.
    busy_d        = state_q != IDLE;
    done_d        = state_q == DONE;
    data_on_pin_d = state_q == HIGH;
    data_pin_d    = strobe_en & shift_q[0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      shift_q       <= '0;
      bit_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      data_pin_q    <= 1'b0;
      data_on_pin_q <= 1'b0;
`ifdef WORD_TX_GAP_EN
      gap_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      data_pin_q    <= data_pin_d;
      data_on_pin_q <= data_on_pin_d;
`ifdef WORD_TX_GAP_EN
      gap_q         <= gap_d;
`endif
    end
  end
  assign bus.addr      = addr_q;
  assign bus.dataPin   = data_pin_q;
  assign bus.dataOnPin = data_on_pin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_word_transmitter.sv
// tb_word_transmitter: scoreboard bench for word_transmitter. The stimulus queues expected words and bursts, and the monitor decodes the serial line.
module tb_word_transmitter;
  import word_transmitter_pkg::*;
  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 8;
`ifdef WORD_TX_GAP_EN
  localparam int GAP_N = GAP_CYCLES;
`else
  localparam int GAP_N = 0;
`endif
  localparam int WORD_CYC = 2 + 64 * CLK_DIV;
  typedef struct {
    logic [31:0] data;
    logic [11:0] addr;
    int          gap;
  } word_exp_t;
  typedef struct {
    int edges;
    int cycles;
  } burst_exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  word_transmitter_if bus();
  word_transmitter #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [4096];
  always @(posedge clk) bus.mem_data <= mem[bus.addr];
  int n_cmp = 0;
  int n_err = 0;
  word_exp_t  qw[$];
  burst_exp_t qb[$];
  int edges_total = 0;
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction
  // monitor: samples on the falling edge and decodes a bit at each rising edge of dataOnPin
  int bit_idx = 0;
  int low_run = 0;
  int gap_cap = 0;
  int burst_edges = 0;
  int busy_run = 0;
  logic prev_on = 1'b0;
  logic [31:0] shreg = '0;
  logic [11:0] addr_cap = '0;
  word_exp_t  we;
  burst_exp_t be;
  always @(negedge clk) begin
    if (!reset) begin
      bit_idx = 0;
      low_run = 0;
      burst_edges = 0;
      busy_run = 0;
      prev_on = 1'b0;
    end else begin
      busy_run = bus.busy ? busy_run + 1 : 0;
      if (bus.dataOnPin && !prev_on) begin
        edges_total++;
        burst_edges++;
        if (bit_idx == 0) begin
          addr_cap = bus.addr;
          gap_cap = low_run;
        end
        shreg = {bus.dataPin, shreg[31:1]};
        bit_idx++;
        if (bit_idx == 32) begin
          bit_idx = 0;
          if (qw.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL word_unexpected: got 0x%0h, expected no word", shreg);
          end else begin
            we = qw.pop_front();
            check("word_data", shreg, we.data);
            check("word_addr", 32'(addr_cap), 32'(we.addr));
            if (we.gap >= 0) check("word_gap_low_cycles", 32'(gap_cap), 32'(we.gap));
          end
        end
      end
      low_run = bus.dataOnPin ? 0 : low_run + 1;
      prev_on = bus.dataOnPin;
      if (bus.done) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done_unexpected: got done=1, expected done=0");
        end else begin
          be = qb.pop_front();
          check("burst_edges", 32'(burst_edges), 32'(be.edges));
          check("burst_busy_cycles", 32'(busy_run), 32'(be.cycles));
          check("busy_with_done", 32'(bus.busy), 32'd1);
        end
        burst_edges = 0;
      end
    end
  end
  task automatic do_start(input logic [11:0] base, input logic [11:0] cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.word_count = cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic expect_burst(input logic [11:0] base, input int n);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      qw.push_back('{mem[a], a, (i == 0) ? -1 : GAP_N + 2 + CLK_DIV});
    end
    if (n == 0) qb.push_back('{0, 1});
    else qb.push_back('{32 * n, n * WORD_CYC + (n - 1) * GAP_N + 1});
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    while ((qw.size() != 0 || qb.size() != 0 || bus.busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("burst_completed_in_budget", 32'((k < budget) ? 1 : 0), 32'd1);
    check("busy_after_burst", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int saved;
    int k;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E3779B1;
    mem[12'h010] = 32'hA5A5_0F0F;
    mem[12'hFFE] = 32'h8000_0001;
    mem[12'hFFF] = 32'hFFFF_FFFF;
    mem[12'h000] = 32'h0000_0000;
    mem[12'h100] = 32'hDEAD_BEEF;
    mem[12'h101] = 32'h0123_4567;
    mem[12'h300] = 32'h1234_5678;
    #23;
    check("reset_addr", 32'(bus.addr), 32'd0);
    check("reset_dataPin", 32'(bus.dataPin), 32'd0);
    check("reset_dataOnPin", 32'(bus.dataOnPin), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    expect_burst(12'h010, 1);
    do_start(12'h010, 12'd1);
    wait_idle(1000);
    expect_burst(12'hFFE, 3);
    do_start(12'hFFE, 12'd3);
    wait_idle(2000);
    expect_burst(12'h050, 0);
    do_start(12'h050, 12'd0);
    check("zero_count_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("zero_count_done_2cyc", 32'(bus.done), 32'd1);
    wait_idle(100);
    expect_burst(12'h100, 2);
    do_start(12'h100, 12'd2);
    repeat (40) @(negedge clk);
    do_start(12'h200, 12'd5);
    wait_idle(2000);
    saved = edges_total;
    k = 0;
    do_start(12'h300, 12'd1);
    while (edges_total < saved + 10 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("abort_edges_before_reset", 32'(edges_total - saved), 32'd10);
    reset = 1'b0;
    #1;
    check("abort_addr", 32'(bus.addr), 32'd0);
    check("abort_dataPin", 32'(bus.dataPin), 32'd0);
    check("abort_dataOnPin", 32'(bus.dataOnPin), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_edges_after_reset", 32'(edges_total - saved), 32'd10);
    expect_burst(12'h300, 1);
    do_start(12'h300, 12'd1);
    wait_idle(1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/word_transmitter.md
WORD_TRANSMITTER -- requirements
Module: word_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per strobe half-period, legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: idle cycles between words, used only when WORD_TX_GAP_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
REQ-006 SHALL have port base_addr, input, 12 bits: first memory address of the burst.
REQ-007 SHALL have port word_count, input, 12 bits: number of words to send.
REQ-008 SHALL have port mem_data, input, 32 bits: synchronous memory read data, valid 1 cycle after addr.
REQ-009 SHALL have port addr, output, 12 bits: memory read address.
REQ-010 SHALL have port dataPin, output, 1 bit: serial data line.
REQ-011 SHALL have port dataOnPin, output, 1 bit: bit strobe; the far end samples dataPin on its rising edge.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at burst end.

Function
REQ-014 SHALL implement states IDLE, FETCH, LOAD, SETUP, HIGH, GAP, DONE.
REQ-015 IDLE: start=1 SHALL latch base_addr into addr and word_count into a remaining counter; next state is FETCH if word_count != 0, else DONE.
REQ-016 start while busy SHALL be ignored with no effect.
REQ-017 FETCH SHALL last 1 cycle (memory latency); LOAD SHALL copy mem_data into a 32-bit shift register and a 5-bit bit counter := 0, then go to SETUP.
REQ-018 Serialization SHALL be LSB first: dataPin = shift_reg[0] throughout SETUP and HIGH.
REQ-019 SETUP SHALL hold dataOnPin=0 for CLK_DIV cycles; HIGH SHALL hold dataOnPin=1 for CLK_DIV cycles, giving a bit period of 2*CLK_DIV cycles and exactly 32 rising strobe edges per word.
REQ-020 Leaving HIGH SHALL shift the register right by 1 and increment the bit counter.
REQ-021 After bit 31: remaining decrements and addr increments by 1, modulo 4096, wrapping 0xFFF -> 0x000.
REQ-022 Next state after bit 31 SHALL be DONE if remaining reaches 0, otherwise GAP (macro defined) or FETCH (macro undefined).
REQ-023 DONE SHALL assert done for 1 cycle, then return to IDLE; done and busy SHALL both be 1 in that cycle.
REQ-024 dataOnPin and dataPin SHALL be 0 in IDLE, FETCH, LOAD, GAP and DONE.
REQ-025 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, addr=0, dataPin=0, dataOnPin=0, busy=0, done=0, and clear shift register and counters.
REQ-027 Reset mid-word SHALL abandon the word with no further strobe edges; the partial word is not resumed after release.

Configuration
REQ-028 Macro WORD_TX_GAP_EN defined: GAP state holds for GAP_CYCLES cycles with dataOnPin=0 between consecutive words, then goes to FETCH.
REQ-029 Macro WORD_TX_GAP_EN undefined: GAP state and its counter SHALL not be generated; consecutive words are separated only by FETCH+LOAD, 2 cycles.

Structure
REQ-030 Shared package SHALL hold the state enum, WORD_W=32 and ADDR_W=12.
REQ-031 One sub-module, word_tx_strobe_gen, SHALL implement the CLK_DIV phase counter and emit a phase-end tick; the FSM, shift register and counters SHALL stay in the top module.

Verification
REQ-032 CLK_DIV=2, base_addr=0x010, word_count=1, mem[0x010]=0xA5A5_0F0F -> 32 strobe edges, sampled bits LSB first reconstruct 0xA5A50F0F, done pulses once, busy low afterwards.
REQ-033 word_count=3, base_addr=0xFFE -> addr sequence 0xFFE, 0xFFF, 0x000, 96 strobe edges, burst duration 3*(2+128) cycles plus DONE, macro undefined.
REQ-034 word_count=0 with start -> no strobe edges, done pulses 2 cycles after start.
REQ-035 start re-pulsed mid-burst with different base_addr -> ignored, original address sequence continues.
REQ-036 reset driven low after the 10th strobe edge of word 0 -> all outputs 0 within the same cycle, no further edges; a fresh start after release sends the full word from bit 0.
REQ-037 WORD_TX_GAP_EN defined, GAP_CYCLES=8, word_count=2 -> dataOnPin is low for 8+2 cycles between the last edge of word 0's final HIGH phase and word 1's first SETUP phase.
